writeback_arbiter: RTL
======================

# writeback_arbiter

Write-side master of the core's register file: merges single-cycle ALU results and variable-latency load results into the one register-file write port (reg_write / write_reg / write_data). Load results are buffered in a small queue and yield to ALU results. A pending-load scoreboard tells the issue stage which destinations are still waiting for load data. Sits between the execute/memory stages and the register file, with a registered output directly driving the register file.

## Interface
- XLEN, 32, data width
- REG_ADDR_W, 5, register index width (NUM_REGS = 2**REG_ADDR_W)
- LQ_DEPTH, 4, load-result queue entries (power of two, >= 2)

- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle (always accepted, no ready)
- alu_rd  in  REG_ADDR_W  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  queue can accept; transfer when ld_valid && ld_ready
- ld_rd  in  REG_ADDR_W  load destination
- ld_data  in  XLEN  load data
- issue_valid  in  1  issue stage dispatching a load
- issue_rd  in  REG_ADDR_W  destination of that load
- reg_write  out  1  register file write enable
- write_reg  out  REG_ADDR_W  register file write index
- write_data  out  XLEN  register file write data
- busy  out  NUM_REGS  per-register pending-load bitmap
- lq_count  out  clog2(LQ_DEPTH)+1  queue occupancy

## Operation
- Reset: reg_write=0, write_reg=0, write_data=0, busy=0, lq_count=0, queue empty; ld_ready=0 while reset is asserted.
- ld_ready = (lq_count < LQ_DEPTH); it does not depend on a same-cycle pop.
- Each cycle, exactly one source is selected, at most one write:
  - ALU: alu_valid=1 selects the ALU.
  - Load: otherwise, if the queue is non-empty, the head is popped.
  - Idle: otherwise no write.
- The selected rd and data are registered onto write_reg/write_data, with reg_write=1.
- Destination x0: if the selected rd==0, reg_write=0 that cycle. The source is still consumed (queue pops). write_reg/write_data hold their previous values.
- Push and pop in the same cycle: lq_count is unchanged. Read/write pointers wrap modulo LQ_DEPTH.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the next edge.
  - busy[rd] clears at the edge after the cycle in which reg_write=1 carries that load's rd. At that point the register file holds the value.
  - If a set and a clear hit the same index on the same edge, the set wins.
  - ALU writes never touch busy.
- Write ordering to the same rd from ALU and load is the issue stage's responsibility; no check is made here.

## Timing
- ALU: alu_valid at cycle N, then reg_write=1 at N+1.
- Load, no contention: accepted at N, head valid at N+1, reg_write=1 at N+2, busy bit clear at N+3.
- Each cycle of alu_valid=1 delays queue draining by one cycle.
- Sustained alu_valid=1 stalls the queue indefinitely; the queue fills and ld_ready drops.
- Throughput: one write per cycle.

## Configuration
- WB_LOAD_BYPASS_EN defined:
  - A load accepted at cycle N with the queue empty and alu_valid=0 bypasses the queue (no push) and is written at N+1.
  - Non-bypass loads behave as above.
- WB_LOAD_BYPASS_EN undefined: every load goes through the queue, giving 2-cycle load-to-write latency.

## Structure
- Shared package riscv_pkg holds:
  - XLEN, REG_ADDR_W, NUM_REGS
  - wb_src_t enum {WB_NONE, WB_ALU, WB_LOAD}, registered with the output so the scoreboard knows which writes retire loads
- Sub-module wb_load_fifo: synchronous FIFO for {rd, data} with push, pop, full, empty and count.
- Selection, output register and scoreboard live in the top module.

## Test plan
- ALU-only: alu_valid, rd=5, data=0xDEADBEEF at N -> reg_write=1, write_reg=5, write_data=0xDEADBEEF at N+1.
- Load path: issue rd=7, then load rd=7, data=0x1234 accepted at N with no ALU traffic -> write at N+2, busy[7] 1 then 0 at N+3. With WB_LOAD_BYPASS_EN: write at N+1.
- Contention: alu_valid for 3 cycles while 2 loads are queued -> 3 ALU writes in order, then both loads in FIFO order, lq_count back to 0.
- Full/wrap: 6 loads offered with alu_valid held 1 and LQ_DEPTH=4 -> ld_ready=0 after 4 accepted. Release the ALU -> all 6 written in order across a pointer wrap.
- x0: ALU and load results with rd=0 -> reg_write stays 0, queue still drains, busy[0] never set.
- Reset mid-operation: assert reset with 3 entries queued and busy bits set -> all outputs 0 immediately, no writes after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: widths and writeback source tags.
// Load-result queue entries are {rd, data}.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2**REG_ADDR_W;
  localparam int WB_ENT_W   = REG_ADDR_W + XLEN;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD
  } wb_src_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_ent_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering load results ahead of the register-file write port.
// Depth is a power of two, so pointers wrap by natural overflow.
module wb_load_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WB_ENT_W-1:0] din,
  input  logic                pop,
  output logic [WB_ENT_W-1:0] dout,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count
);

  logic [WB_ENT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write master: ALU results win, queued loads fill idle slots.
// WB_LOAD_BYPASS_EN lets a load arriving at an idle, empty queue skip it.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter  int LQ_DEPTH = 4,
  localparam int CW       = $clog2(LQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   busy,
  output logic [CW-1:0]         lq_count
);

  wb_ent_t ld_ent, head;
  logic    full, empty, push, pop, byp, ld_acc;

  wb_src_t               sel;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  we_d;

  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] write_reg_q;
  logic [XLEN-1:0]       write_data_q;
  wb_src_t               src_q;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign ld_ent   = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !reset && !full;
  assign ld_acc   = ld_valid && ld_ready;

`ifdef WB_LOAD_BYPASS_EN
  assign byp = !alu_valid && empty && ld_acc;
`else
  assign byp = 1'b0;
`endif

  assign push = ld_acc && !byp;

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ld_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (lq_count)
  );

  always_comb begin
    sel      = WB_NONE;
    sel_rd   = '0;
    sel_data = '0;
    pop      = 1'b0;
    unique case (1'b1)
      alu_valid: begin
        sel      = WB_ALU;
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      (!alu_valid && !empty): begin
        sel      = WB_LOAD;
        sel_rd   = head.rd;
        sel_data = head.data;
        pop      = 1'b1;
      end
      byp: begin
        sel      = WB_LOAD;
        sel_rd   = ld_rd;
        sel_data = ld_data;
      end
      default: ;
    endcase
  end

  // x0 writes are swallowed; the source is still consumed
  assign we_d = (sel != WB_NONE) && (sel_rd != '0);

  // a set on the same edge as a retiring load wins
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q && src_q == WB_LOAD) busy_d[write_reg_q] = 1'b0;
    if (issue_valid && issue_rd != '0)   busy_d[issue_rd]    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      src_q        <= WB_NONE;
      busy_q       <= '0;
    end else begin
      reg_write_q <= we_d;
      src_q       <= we_d ? sel : WB_NONE;
      busy_q      <= busy_d;
      if (we_d) begin
        write_reg_q  <= sel_rd;
        write_data_q <= sel_data;
      end
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;

endmodule
